// File: rtl/ecc_secded_pipe_pkg.sv
// Shared types and width helpers for the SECDED Hamming codec.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_OK = 2'b00,
        ECC_CE = 2'b01,
        ECC_UE = 2'b10
    } ecc_status_e;

    // Smallest p with 2**p >= dw + p + 1.
    function automatic int unsigned ecc_pw(int unsigned dw);
        int unsigned p;
        p = 0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (p == 0 && (32'd1 << i) >= dw + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic int unsigned ecc_cw(int unsigned dw);
        return dw + ecc_pw(dw) + 1;
    endfunction

    // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two position.
    function automatic int unsigned ecc_dpos(int unsigned idx);
        int unsigned n;
        int unsigned pos;
        n   = 0;
        pos = 0;
        for (int unsigned p = 1; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx && pos == 0) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Write/encode and read/decode channels plus counter signals of the SECDED codec.
interface ecc_secded_pipe_if
    import ecc_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned CNTW = 16
);
    localparam int unsigned PW = ecc_pw(DW);
    localparam int unsigned CW = ecc_cw(DW);

    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   wr_data;
    logic [CW-1:0]   inj_mask;
    logic            enc_valid;
    logic            enc_ready;
    logic [CW-1:0]   enc_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [CW-1:0]   rd_code;
    logic            dec_valid;
    logic            dec_ready;
    logic [DW-1:0]   dec_data;
    logic [1:0]      dec_status;
    logic [PW-1:0]   dec_synd;
    logic [CNTW-1:0] ce_cnt;
    logic [CNTW-1:0] ue_cnt;
    logic            cnt_clr;

    modport master (
        output wr_valid, wr_data, inj_mask, enc_ready, rd_valid, rd_code, dec_ready, cnt_clr,
        input  wr_ready, enc_valid, enc_data, rd_ready, dec_valid, dec_data, dec_status,
               dec_synd, ce_cnt, ue_cnt
    );

    modport slave (
        input  wr_valid, wr_data, inj_mask, enc_ready, rd_valid, rd_code, dec_ready, cnt_clr,
        output wr_ready, enc_valid, enc_data, rd_ready, dec_valid, dec_data, dec_status,
               dec_synd, ce_cnt, ue_cnt
    );

endinterface

// File: rtl/ecc_secded_pipe_hamming_core.sv
// Combinational Hamming parity/syndrome generator: bit k of the result is the XOR of
// all positions (1-based) whose index has bit k set.
module ecc_hamming_core
    import ecc_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [ecc_pw(DW)+DW-1:0] i_bits,
    output logic [ecc_pw(DW)-1:0]    o_synd
);
    localparam int unsigned PW = ecc_pw(DW);
    localparam int unsigned NB = DW + PW;

    for (genvar k = 0; k < PW; k++) begin : g_bit
        logic [NB-1:0] w_cov;
        for (genvar p = 1; p <= NB; p++) begin : g_pos
            if (((p >> k) & 1) != 0) begin : g_in
                assign w_cov[p-1] = i_bits[p-1];
            end else begin : g_out
                assign w_cov[p-1] = 1'b0;
            end
        end
        assign o_synd[k] = ^w_cov;
    end

endmodule

// File: rtl/ecc_secded_pipe.sv
// SECDED codec: one registered valid/ready stage per direction (encode, decode/correct)
// plus saturating CE/UE counters.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    ecc_secded_pipe_if.slave  bus
);
    localparam int unsigned PW = ecc_pw(DW);
    localparam int unsigned CW = ecc_cw(DW);
    localparam int unsigned NB = DW + PW;

    // Encode: scatter data, parity slots zero, then drop the syndrome into the parity slots.
    logic [NB-1:0] w_enc_scatter;
    logic [NB-1:0] w_enc_body;
    logic [PW-1:0] w_enc_synd;
    logic [CW-1:0] w_enc_code;

    for (genvar i = 0; i < DW; i++) begin : g_enc_data
        localparam int unsigned POS = ecc_dpos(i);
        assign w_enc_scatter[POS-1] = bus.wr_data[i];
        assign w_enc_body[POS-1]    = bus.wr_data[i];
    end
    for (genvar k = 0; k < PW; k++) begin : g_enc_par
        localparam int unsigned POS = 32'd1 << k;
        assign w_enc_scatter[POS-1] = 1'b0;
        assign w_enc_body[POS-1]    = w_enc_synd[k];
    end

    ecc_hamming_core #(.DW(DW)) u_enc_core (.i_bits(w_enc_scatter), .o_synd(w_enc_synd));
    assign w_enc_code = {^w_enc_body, w_enc_body};

    logic          r_enc_valid;
    logic [CW-1:0] r_enc_data;
    logic          w_wr_ready;
    logic          w_wr_fire;

    assign w_wr_ready = !r_enc_valid || bus.enc_ready;
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_valid <= 1'b0;
            r_enc_data  <= '0;
        end else if (w_wr_fire) begin
            r_enc_valid <= 1'b1;
            r_enc_data  <= w_enc_code ^ bus.inj_mask;
        end else if (bus.enc_ready) begin
            r_enc_valid <= 1'b0;
        end
    end

    // Decode: syndrome over [CW-2:0], overall parity over every bit.
    logic [NB-1:0] w_rd_body;
    logic [PW-1:0] w_rd_synd;
    logic          w_rd_par;
    logic          w_synd_zero;
    logic          w_synd_hit;
    logic          w_do_fix;
    logic [NB-1:0] w_flip;
    logic [NB-1:0] w_fixed;
    logic [DW-1:0] w_rd_data;
    ecc_status_e   w_rd_status;

    assign w_rd_body = bus.rd_code[NB-1:0];
    ecc_hamming_core #(.DW(DW)) u_dec_core (.i_bits(w_rd_body), .o_synd(w_rd_synd));

    assign w_rd_par    = ^bus.rd_code;
    assign w_synd_zero = (w_rd_synd == '0);
    assign w_synd_hit  = (w_rd_synd <= PW'(NB));
    assign w_do_fix    = w_rd_par && !w_synd_zero && w_synd_hit;

    for (genvar p = 1; p <= NB; p++) begin : g_flip
        assign w_flip[p-1] = w_do_fix && (w_rd_synd == PW'(p));
    end
    assign w_fixed = w_rd_body ^ w_flip;

    for (genvar i = 0; i < DW; i++) begin : g_dec_data
        localparam int unsigned POS = ecc_dpos(i);
        assign w_rd_data[i] = w_fixed[POS-1];
    end

    always_comb begin
        w_rd_status = ECC_UE;
        if (!w_rd_par && w_synd_zero) begin
            w_rd_status = ECC_OK;
        end else if (w_rd_par && w_synd_hit) begin
            w_rd_status = ECC_CE;
        end
    end

    logic          r_dec_valid;
    logic [DW-1:0] r_dec_data;
    ecc_status_e   r_dec_status;
    logic [PW-1:0] r_dec_synd;
    logic          w_rd_ready;
    logic          w_rd_fire;

    assign w_rd_ready = !r_dec_valid || bus.dec_ready;
    assign w_rd_fire  = bus.rd_valid && w_rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid  <= 1'b0;
            r_dec_data   <= '0;
            r_dec_status <= ECC_OK;
            r_dec_synd   <= '0;
        end else if (w_rd_fire) begin
            r_dec_valid  <= 1'b1;
            r_dec_data   <= w_rd_data;
            r_dec_status <= w_rd_status;
            r_dec_synd   <= w_rd_synd;
        end else if (bus.dec_ready) begin
            r_dec_valid  <= 1'b0;
        end
    end

    // Counters count delivered results; a clear coinciding with an increment leaves 1.
    logic [CNTW-1:0] r_ce_cnt;
    logic [CNTW-1:0] r_ue_cnt;
    logic            w_ce_inc;
    logic            w_ue_inc;

    assign w_ce_inc = r_dec_valid && bus.dec_ready && (r_dec_status == ECC_CE);
    assign w_ue_inc = r_dec_valid && bus.dec_ready && (r_dec_status == ECC_UE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else begin
            if (bus.cnt_clr) r_ce_cnt <= w_ce_inc ? CNTW'(1) : '0;
            else if (w_ce_inc && r_ce_cnt != '1) r_ce_cnt <= r_ce_cnt + CNTW'(1);
            if (bus.cnt_clr) r_ue_cnt <= w_ue_inc ? CNTW'(1) : '0;
            else if (w_ue_inc && r_ue_cnt != '1) r_ue_cnt <= r_ue_cnt + CNTW'(1);
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.enc_valid  = r_enc_valid;
    assign bus.enc_data   = r_enc_data;
    assign bus.rd_ready   = w_rd_ready;
    assign bus.dec_valid  = r_dec_valid;
    assign bus.dec_data   = r_dec_data;
    assign bus.dec_status = r_dec_status;
    assign bus.dec_synd   = r_dec_synd;
    assign bus.ce_cnt     = r_ce_cnt;
    assign bus.ue_cnt     = r_ue_cnt;

endmodule
